// File: rtl/echo_unit_pkg.sv
// rtl/echo_unit_pkg.sv - shared state encoding, saturation limits and helpers for the echo stage
package echo_unit_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_MIX   = 2'd3
  } state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // Clamp a 17-bit sum to 16 bits; bits 16 and 15 differ only when the sum left the 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      sat16 = v[16] ? SAT_MIN : SAT_MAX;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

endpackage

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - single-port synchronous delay-line RAM with one-cycle read
module echo_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read-before-write port; contents are not reset because the owner clears them after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_unit.sv
// rtl/echo_unit.sv - echo stage mixing each sample with an attenuated copy from a circular delay line
module echo_unit
  import echo_unit_pkg::*;
#(
  parameter int DELAY_SAMPLES = 1000,
  parameter int ADDR_WIDTH    = 10,
  parameter int ATTEN_SHIFT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               feedback,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  output logic               ready,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic               overrun
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY_SAMPLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic signed [15:0]      s_reg;
  logic signed [15:0]      d_reg;
  logic signed [15:0]      ram_rdata;
  logic signed [15:0]      ram_wdata;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic signed [16:0]      s_ext;
  logic signed [16:0]      d_ext;
  logic signed [16:0]      wet_wide;
  logic signed [15:0]      wet;
  logic                    accept;
  logic                    ptr_last;
  logic [ADDR_WIDTH-1:0]   ptr_next;

  // The pointer walks 0..DELAY_SAMPLES-1 and wraps, so the line depth is DELAY_SAMPLES, not the RAM size.
  assign ptr_last = (ptr == LAST_ADDR);
  assign ptr_next = ptr_last ? '0 : ptr + 1'b1;

  assign accept   = ready & sample_in_valid;

  // Wet mix in 17 bits so the sum cannot wrap before saturation.
  assign s_ext    = {s_reg[15], s_reg};
  assign d_ext    = {d_reg[15], d_reg};
  assign wet_wide = s_ext + (d_ext >>> ATTEN_SHIFT);
  assign wet      = sat16(wet_wide);

  echo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (16)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset always restarts with a full clear of the delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clear sweep, then one READ/MIX pass per accepted sample.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (ptr_last) state_nxt = ST_IDLE;
      ST_IDLE:  if (accept)   state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_MIX;
      ST_MIX:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Outputs: RAM is always addressed at ptr, so the IDLE-cycle read lands in READ.
  // ready stays low in the cycle the output pulses, giving a three-cycle busy window.
  always_comb begin
    ready     = (state == ST_IDLE) && !sample_out_valid;
    ram_we    = 1'b0;
    ram_addr  = ptr;
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = '0;
      end
      ST_MIX: begin
        ram_we    = 1'b1;
        ram_wdata = (feedback && enable) ? wet : s_reg;
      end
      default: begin
        ram_we    = 1'b0;
      end
    endcase
  end

  // Datapath registers, pointer advance and the sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr              <= '0;
      s_reg            <= '0;
      d_reg            <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      sample_out_valid <= 1'b0;
      case (state)
        ST_CLEAR: ptr <= ptr_next;
        ST_IDLE:  if (accept) s_reg <= sample_in;
        ST_READ:  d_reg <= ram_rdata;
        ST_MIX: begin
          sample_out       <= enable ? wet : s_reg;
          sample_out_valid <= 1'b1;
          ptr              <= ptr_next;
        end
        default: ;
      endcase
      if (sample_in_valid && !ready && (state != ST_CLEAR)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_unit.sv
// tb/tb_echo_unit.sv - randomized directed bench for echo_unit against a delay-queue reference model
module tb_echo_unit;

  localparam int D  = 4;
  localparam int AW = 3;
  localparam int AT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        feedback = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_in_valid = 1'b0;
  logic        ready;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        overrun;

  int          n_vec = 0;
  int          miscompares = 0;
  int          dline[$];
  logic [15:0] last_out;

  echo_unit #(
    .DELAY_SAMPLES (D),
    .ADDR_WIDTH    (AW),
    .ATTEN_SHIFT   (AT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .feedback         (feedback),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .ready            (ready),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dline.delete();
    for (int i = 0; i < D; i++) dline.push_back(0);
  endtask

  // Each output sees the value stored D samples earlier; the stored value is wet or dry by mode.
  function automatic logic [15:0] model_step(input int x, input bit en, input bit fb);
    int echo;
    int wet;
    echo = dline.pop_front();
    wet  = x + (echo >>> AT);
    if (wet > 32767) wet = 32767;
    else if (wet < -32768) wet = -32768;
    dline.push_back((en && fb) ? wet : x);
    return en ? 16'(wet) : 16'(x);
  endfunction

  task automatic clear_wait(input bit poke);
    for (int i = 1; i <= D; i++) begin
      @(posedge clk); #1;
      if (i < D) check("clear_ready_low", ready, 0);
      else       check("ready_rise", ready, 1);
      check("clear_no_valid", sample_out_valid, 0);
      if (poke && i < D) begin
        sample_in       = 16'($urandom);
        sample_in_valid = 1'b1;
      end else begin
        sample_in_valid = 1'b0;
      end
    end
    check("clear_overrun", overrun, 0);
  endtask

  task automatic do_reset(input bit poke);
    @(negedge clk);
    reset           = 1'b0;
    sample_in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_out", sample_out, 0);
    check("rst_valid", sample_out_valid, 0);
    check("rst_ready", ready, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    clear_wait(poke);
  endtask

  task automatic send(input logic [15:0] s, input bit en, input bit fb, input bit dbl);
    logic [15:0] exp;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", ready, 1);
    exp             = model_step(int'($signed(s)), en, fb);
    sample_in       = s;
    sample_in_valid = 1'b1;
    enable          = en;
    feedback        = fb;
    @(posedge clk); #1;
    if (dbl) sample_in = 16'($urandom);
    else     sample_in_valid = 1'b0;
    check("n1_valid", sample_out_valid, 0);
    check("n1_ready", ready, 0);
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    check("n2_valid", sample_out_valid, 0);
    check("n2_ready", ready, 0);
    if (dbl) check("overrun_set", overrun, 1);
    @(posedge clk); #1;
    check("n3_valid", sample_out_valid, 1);
    check("n3_data", sample_out, exp);
    check("n3_ready", ready, 0);
    last_out = sample_out;
    @(posedge clk); #1;
    check("n4_valid", sample_out_valid, 0);
    check("n4_ready", ready, 1);
  endtask

  initial begin
    logic [15:0] dry[4];

    // 1: reset timing and single echo
    do_reset(1'b0);
    send(16'd100, 1'b1, 1'b0, 1'b0);
    check("t1_first", last_out, 16'd100);
    for (int i = 0; i < 3; i++) send(16'd0, 1'b1, 1'b0, 1'b0);
    send(16'd0, 1'b1, 1'b0, 1'b0);
    check("t1_echo", last_out, 16'd50);

    // 2: feedback repeating echo
    do_reset(1'b0);
    send(16'd1000, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      send(16'd0, 1'b1, 1'b1, 1'b0);
      if (k == 4)  check("t2_k4", last_out, 16'd500);
      if (k == 8)  check("t2_k8", last_out, 16'd250);
      if (k == 12) check("t2_k12", last_out, 16'd125);
    end

    // 3: saturation both ways
    do_reset(1'b0);
    send(16'd30000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(16'd0, 1'b1, 1'b0, 1'b0);
    send(16'd30000, 1'b1, 1'b0, 1'b0);
    check("t3_sat_pos", last_out, 16'h7FFF);
    do_reset(1'b0);
    send(16'(-30000), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(16'd0, 1'b1, 1'b0, 1'b0);
    send(16'(-30000), 1'b1, 1'b0, 1'b0);
    check("t3_sat_neg", last_out, 16'h8000);

    // 4: dry pass-through, then echo of the dry samples
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      dry[i] = 16'($urandom);
      send(dry[i], 1'b0, 1'b1, 1'b0);
      check("t4_dry", last_out, dry[i]);
    end
    for (int i = 0; i < 4; i++) send(16'd0, 1'b1, 1'b0, 1'b0);

    // 5: pokes during clear, then back-to-back pulses
    do_reset(1'b1);
    send(16'($urandom), 1'b1, 1'b0, 1'b1);
    send(16'($urandom), 1'b1, 1'b0, 1'b0);
    check("t5_sticky", overrun, 1);

    // 6: reset during READ, then pointer wrap
    do_reset(1'b0);
    send(16'd1234, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    sample_in       = 16'd777;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    reset           = 1'b0;
    #1;
    check("t6_rst_out", sample_out, 0);
    check("t6_rst_valid", sample_out_valid, 0);
    check("t6_rst_ready", ready, 0);
    @(posedge clk); #1;
    check("t6_no_pulse", sample_out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    clear_wait(1'b0);
    for (int i = 0; i < 12; i++) send(16'($urandom), 1'b1, 1'b0, 1'b0);

    // Random mode mix
    for (int i = 0; i < 24; i++) begin
      send(16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
